// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
//  Module   : lc3b_types (package)
//  Purpose  : Shared defaults and types for the decode/issue stage.
//             - LC3B_* constants hold the parameter defaults of the stage.
//             - lc3b_sb_cnt holds one scoreboard counter at the default
//               MAX_INFLIGHT.
//             - lc3b_issue_pkt bundles one ID/EX slot entry at the default
//               widths.
//  Ports    : none (package)
//  Options  : DECODE_WB_BYPASS_EN (used by importers, not here)
//  Revision : 1.0  initial release
// ============================================================================
package lc3b_types;

   localparam int LC3B_WIDTH        = 16;
   localparam int LC3B_NUM_REGS     = 8;
   localparam int LC3B_MAX_INFLIGHT = 3;
   localparam int LC3B_REG_W        = $clog2(LC3B_NUM_REGS);
   localparam int LC3B_CNT_W        = $clog2(LC3B_MAX_INFLIGHT + 1);

   typedef logic [LC3B_CNT_W-1:0] lc3b_sb_cnt;

   typedef struct packed {
      logic [LC3B_WIDTH-1:0] sr1;
      logic [LC3B_WIDTH-1:0] sr2;
      logic [LC3B_REG_W-1:0] dest;
      logic                  dest_en;
      logic [LC3B_WIDTH-1:0] ctrl;
   } lc3b_issue_pkt;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : decode_scoreboard
//  Purpose  : Per-register pending-write counters plus the RAW-hazard and
//             destination-full decisions for the decode/issue stage.
//  Ports    : clk, reset (async, active-high)
//             src1/src1_en, src2/src2_en, dest/dest_en : instruction selects
//             issue                 : instruction issued at this edge
//             wb_valid/wb_reg       : writeback retiring a write
//             kill_valid/kill_reg   : flushed slot entry dropping its write
//             hazard                : an enabled source has pending writes
//             dest_full             : destination already at MAX_INFLIGHT
//  Options  : DECODE_WB_BYPASS_EN - a source whose only pending write is
//             being written back this cycle is not a hazard.
//  Revision : 1.0  initial release
// ============================================================================
module decode_scoreboard
   import lc3b_types::*;
#(
   parameter int NUM_REGS     = LC3B_NUM_REGS,
   parameter int MAX_INFLIGHT = LC3B_MAX_INFLIGHT,
   parameter int REG_W        = $clog2(NUM_REGS),
   parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] src1,
   input  logic             src1_en,
   input  logic [REG_W-1:0] src2,
   input  logic             src2_en,
   input  logic [REG_W-1:0] dest,
   input  logic             dest_en,
   input  logic             issue,
   input  logic             wb_valid,
   input  logic [REG_W-1:0] wb_reg,
   input  logic             kill_valid,
   input  logic [REG_W-1:0] kill_reg,
   output logic             hazard,
   output logic             dest_full
);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_MAX = cnt_t'(MAX_INFLIGHT);
   localparam cnt_t CNT_ONE = cnt_t'(1);

   // Flat view of all counters so the hazard logic can index by select.
   logic [NUM_REGS-1:0][CNT_W-1:0] cnt_vec;

   logic src1_hazard;
   logic src2_hazard;

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
      cnt_t cnt_q;
      cnt_t cnt_d;
      logic inc;
      logic dec;

      assign inc = issue && dest_en && (dest == REG_W'(r));
      // A register retires at most one write per cycle: a writeback and a
      // kill landing on the same register collapse into a single decrement,
      // and nothing is retired from an empty counter.
      assign dec = ((wb_valid && (wb_reg == REG_W'(r))) ||
                    (kill_valid && (kill_reg == REG_W'(r)))) &&
                   (cnt_q != '0);

      always_comb begin
         cnt_d = cnt_q;
         if (inc && !dec) begin
            cnt_d = cnt_q + CNT_ONE;
         end else if (dec && !inc) begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign cnt_vec[r] = cnt_q;
   end

   always_comb begin
      src1_hazard = src1_en && (cnt_vec[src1] != '0);
      src2_hazard = src2_en && (cnt_vec[src2] != '0);
`ifdef DECODE_WB_BYPASS_EN
      // The last outstanding write arrives this cycle; the top forwards
      // wb_data into the operand, so the dependency is already satisfied.
      if (wb_valid && (wb_reg == src1) && (cnt_vec[src1] == CNT_ONE)) begin
         src1_hazard = 1'b0;
      end
      if (wb_valid && (wb_reg == src2) && (cnt_vec[src2] == CNT_ONE)) begin
         src2_hazard = 1'b0;
      end
`endif
      hazard    = src1_hazard || src2_hazard;
      dest_full = dest_en && (cnt_vec[dest] == CNT_MAX);
   end

endmodule : decode_scoreboard
`default_nettype wire

// File: rtl/decode_issue_sb.sv
`default_nettype none
// ============================================================================
//  Module   : decode_issue_sb
//  Purpose  : Decode/issue stage with NUM_REGS x WIDTH register file and a
//             pending-write scoreboard.  Stalls on RAW hazards and on a full
//             destination counter and registers operands into a valid/ready
//             ID/EX slot (1-cycle latency, full throughput).
//  Ports    : clk, reset (async, active-high)
//             in_valid/in_ready     : upstream handshake
//             in_src1/2, in_dest (+ _en), in_ctrl : instruction fields
//             wb_valid/wb_reg/wb_data : writeback port
//             flush                 : kill held slot, block issue this cycle
//             out_valid/out_ready   : ID/EX slot handshake
//             out_sr1/2, out_dest, out_dest_en, out_ctrl : slot contents
//  Options  : DECODE_WB_BYPASS_EN - forward wb_data into source operands and
//             clear the hazard on the final pending write.
//  Revision : 1.0  initial release
// ============================================================================
module decode_issue_sb
   import lc3b_types::*;
#(
   parameter int WIDTH        = LC3B_WIDTH,
   parameter int NUM_REGS     = LC3B_NUM_REGS,
   parameter int MAX_INFLIGHT = LC3B_MAX_INFLIGHT,
   localparam int REG_W       = $clog2(NUM_REGS),
   localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [REG_W-1:0] in_src1,
   input  logic [REG_W-1:0] in_src2,
   input  logic [REG_W-1:0] in_dest,
   input  logic             in_src1_en,
   input  logic             in_src2_en,
   input  logic             in_dest_en,
   input  logic [WIDTH-1:0] in_ctrl,
   input  logic             wb_valid,
   input  logic [REG_W-1:0] wb_reg,
   input  logic [WIDTH-1:0] wb_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sr1,
   output logic [WIDTH-1:0] out_sr2,
   output logic [REG_W-1:0] out_dest,
   output logic             out_dest_en,
   output logic [WIDTH-1:0] out_ctrl
);

   // Same layout as lc3b_issue_pkt, sized by this instance's parameters.
   typedef struct packed {
      logic [WIDTH-1:0] sr1;
      logic [WIDTH-1:0] sr2;
      logic [REG_W-1:0] dest;
      logic             dest_en;
      logic [WIDTH-1:0] ctrl;
   } issue_pkt_t;

   logic [WIDTH-1:0] rf_q [NUM_REGS];
   logic [WIDTH-1:0] rf_d [NUM_REGS];

   issue_pkt_t slot_q;
   issue_pkt_t slot_d;
   logic       out_valid_q;
   logic       out_valid_d;

   logic [WIDTH-1:0] sr1_val;
   logic [WIDTH-1:0] sr2_val;

   logic sb_hazard;
   logic sb_dest_full;
   logic can_issue;
   logic slot_free;
   logic issue;
   logic kill_valid;

   // ------------------------------------------------------------------
   // Handshake.  in_ready never looks at in_valid.
   // ------------------------------------------------------------------
   assign can_issue  = !sb_hazard && !sb_dest_full && !flush;
   assign slot_free  = !out_valid_q || out_ready;
   assign in_ready   = can_issue && slot_free;
   assign issue      = in_valid && in_ready;

   // A flushed slot entry that would have written a register gives its
   // scoreboard reservation back.
   assign kill_valid = flush && out_valid_q && slot_q.dest_en;

   decode_scoreboard #(
      .NUM_REGS     (NUM_REGS),
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .REG_W        (REG_W),
      .CNT_W        (CNT_W)
   ) u_sb (
      .clk        (clk),
      .reset      (reset),
      .src1       (in_src1),
      .src1_en    (in_src1_en),
      .src2       (in_src2),
      .src2_en    (in_src2_en),
      .dest       (in_dest),
      .dest_en    (in_dest_en),
      .issue      (issue),
      .wb_valid   (wb_valid),
      .wb_reg     (wb_reg),
      .kill_valid (kill_valid),
      .kill_reg   (slot_q.dest),
      .hazard     (sb_hazard),
      .dest_full  (sb_dest_full)
   );

   // ------------------------------------------------------------------
   // Operand read.  Disabled sources still read so the slot shows the raw
   // register value.
   // ------------------------------------------------------------------
   always_comb begin
      sr1_val = rf_q[in_src1];
      sr2_val = rf_q[in_src2];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_valid && (wb_reg == in_src1)) begin
         sr1_val = wb_data;
      end
      if (wb_valid && (wb_reg == in_src2)) begin
         sr2_val = wb_data;
      end
`endif
   end

   // ------------------------------------------------------------------
   // Register file.  Writeback always writes, even with no pending count,
   // so registers can be initialised straight after reset.
   // ------------------------------------------------------------------
   always_comb begin
      rf_d = rf_q;
      if (wb_valid) begin
         rf_d[wb_reg] = wb_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         rf_q <= rf_d;
      end
   end

   // ------------------------------------------------------------------
   // ID/EX slot.  Data holds when the slot empties; only valid drops.
   // ------------------------------------------------------------------
   always_comb begin
      slot_d      = slot_q;
      out_valid_d = out_valid_q;
      if (issue) begin
         slot_d.sr1     = sr1_val;
         slot_d.sr2     = sr2_val;
         slot_d.dest    = in_dest;
         slot_d.dest_en = in_dest_en;
         slot_d.ctrl    = in_ctrl;
         out_valid_d    = 1'b1;
      end else if (out_ready || flush) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_sr1     = slot_q.sr1;
   assign out_sr2     = slot_q.sr2;
   assign out_dest    = slot_q.dest;
   assign out_dest_en = slot_q.dest_en;
   assign out_ctrl    = slot_q.ctrl;

endmodule : decode_issue_sb
`default_nettype wire

// File: tb/tb_decode_issue_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_issue_sb
//  Purpose  : Self-checking bench for decode_issue_sb (default parameters).
//             Directed scenarios plus a randomized run against a
//             behavioural model of the register file, counters and slot.
//  Options  : DECODE_WB_BYPASS_EN changes the expected stall timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_issue_sb;

   localparam int WIDTH    = 16;
   localparam int NUM_REGS = 8;
   localparam int MAX_INF  = 3;
   localparam int REG_W    = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [REG_W-1:0] in_src1, in_src2, in_dest;
   logic             in_src1_en, in_src2_en, in_dest_en;
   logic [WIDTH-1:0] in_ctrl;
   logic             wb_valid;
   logic [REG_W-1:0] wb_reg;
   logic [WIDTH-1:0] wb_data;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sr1, out_sr2, out_ctrl;
   logic [REG_W-1:0] out_dest;
   logic             out_dest_en;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decode_issue_sb dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
      .in_src1_en(in_src1_en), .in_src2_en(in_src2_en), .in_dest_en(in_dest_en),
      .in_ctrl(in_ctrl),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sr1(out_sr1), .out_sr2(out_sr2), .out_dest(out_dest),
      .out_dest_en(out_dest_en), .out_ctrl(out_ctrl)
   );

   // ---------------- reference model ----------------
   logic [WIDTH-1:0] m_rf [NUM_REGS];
   int               m_cnt [NUM_REGS];
   logic             m_valid;
   logic [WIDTH-1:0] m_sr1, m_sr2, m_ctrl;
   logic [REG_W-1:0] m_dest;
   logic             m_dest_en;

   task automatic m_reset();
      for (int i = 0; i < NUM_REGS; i++) begin
         m_rf[i]  = '0;
         m_cnt[i] = 0;
      end
      m_valid = 0; m_sr1 = '0; m_sr2 = '0; m_ctrl = '0; m_dest = '0; m_dest_en = 0;
   endtask

   function automatic bit m_src_hazard(bit en, int s);
      if (!en || m_cnt[s] == 0) return 0;
`ifdef DECODE_WB_BYPASS_EN
      if (wb_valid && int'(wb_reg) == s && m_cnt[s] == 1) return 0;
`endif
      return 1;
   endfunction

   function automatic bit m_ready();
      if (flush) return 0;
      if (m_src_hazard(in_src1_en, int'(in_src1))) return 0;
      if (m_src_hazard(in_src2_en, int'(in_src2))) return 0;
      if (in_dest_en && m_cnt[in_dest] == MAX_INF) return 0;
      return !m_valid || out_ready;
   endfunction

   function automatic logic [WIDTH-1:0] m_read(int s);
`ifdef DECODE_WB_BYPASS_EN
      if (wb_valid && int'(wb_reg) == s) return wb_data;
`endif
      return m_rf[s];
   endfunction

   task automatic m_edge();
      bit iss;
      logic [WIDTH-1:0] a, b;
      iss = in_valid && m_ready();
      a = m_read(int'(in_src1));
      b = m_read(int'(in_src2));
      for (int r = 0; r < NUM_REGS; r++) begin
         bit up, down;
         up   = iss && in_dest_en && int'(in_dest) == r;
         down = m_cnt[r] > 0 &&
                ((wb_valid && int'(wb_reg) == r) ||
                 (flush && m_valid && m_dest_en && int'(m_dest) == r));
         m_cnt[r] = m_cnt[r] + int'(up) - int'(down);
      end
      if (wb_valid) m_rf[wb_reg] = wb_data;
      if (iss) begin
         m_valid = 1; m_sr1 = a; m_sr2 = b;
         m_dest = in_dest; m_dest_en = in_dest_en; m_ctrl = in_ctrl;
      end else if (out_ready || flush) begin
         m_valid = 0;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      if (reset) m_reset(); else m_edge();
      @(negedge clk);
   endtask

   task automatic drive(bit v, int s1, bit s1e, int s2, bit s2e, int d, bit de,
                        logic [WIDTH-1:0] ctrl);
      in_valid = v;
      in_src1 = REG_W'(s1); in_src1_en = s1e;
      in_src2 = REG_W'(s2); in_src2_en = s2e;
      in_dest = REG_W'(d);  in_dest_en = de;
      in_ctrl = ctrl;
   endtask

   task automatic drive_wb(bit v, int r, logic [WIDTH-1:0] d);
      wb_valid = v; wb_reg = REG_W'(r); wb_data = d;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, '0);
      drive_wb(0, 0, '0);
      flush = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1; out_ready = 1; idle();
      m_reset();
      #2;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: out_valid=%b expected 0", out_valid);
      end
      checks++;
      if ({out_sr1, out_sr2, out_ctrl, out_dest, out_dest_en} !== '0) begin
         errors++;
         $display("FAIL reset_data: sr1=%h sr2=%h ctrl=%h dest=%0d en=%b expected all 0",
                  out_sr1, out_sr2, out_ctrl, out_dest, out_dest_en);
      end
      @(negedge clk);
      reset = 0;
      // Initialise Rk = k through writeback with empty counters.
      for (int k = 0; k < NUM_REGS; k++) begin
         drive_wb(1, k, WIDTH'(k));
         step();
      end
      idle();
   endtask

   task automatic test_back_to_back();
      out_ready = 1;
      drive(1, 2, 1, 0, 0, 1, 1, 16'h1111);
      #1; checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_ready1: in_ready=%b expected 1", in_ready);
      end
      step();
      drive(1, 4, 1, 0, 0, 3, 1, 16'h3333);
      #1; checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_ready2: in_ready=%b expected 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || out_sr1 !== 16'h0002 || out_dest !== 3'd1) begin
         errors++;
         $display("FAIL b2b_first: valid=%b sr1=%h dest=%0d expected 1/0002/1",
                  out_valid, out_sr1, out_dest);
      end
      step();
      idle();
      checks++;
      if (out_valid !== 1'b1 || out_sr1 !== 16'h0004 || out_dest !== 3'd3 ||
          out_ctrl !== 16'h3333) begin
         errors++;
         $display("FAIL b2b_second: valid=%b sr1=%h dest=%0d ctrl=%h expected 1/0004/3/3333",
                  out_valid, out_sr1, out_dest, out_ctrl);
      end
      drive_wb(1, 1, 16'h0001); step();
      drive_wb(1, 3, 16'h0003); step();
      idle();
   endtask

   task automatic test_raw();
      out_ready = 1;
      drive(1, 0, 0, 0, 0, 1, 1, 16'hA001);
      step();
      drive(1, 1, 1, 0, 0, 7, 1, 16'hA002);
      #1; checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL raw_stall1: in_ready=%b expected 0", in_ready);
      end
      step();
      #1; checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL raw_stall2: in_ready=%b expected 0", in_ready);
      end
      drive_wb(1, 1, 16'hBEEF);
      #1; checks++;
`ifdef DECODE_WB_BYPASS_EN
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL raw_wb_cycle: in_ready=%b expected 1", in_ready);
      end
      step();
      idle();
`else
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL raw_wb_cycle: in_ready=%b expected 0", in_ready);
      end
      step();
      drive_wb(0, 0, '0);
      #1; checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL raw_after_wb: in_ready=%b expected 1", in_ready);
      end
      step();
      idle();
`endif
      checks++;
      if (out_valid !== 1'b1 || out_sr1 !== 16'hBEEF || out_dest !== 3'd7) begin
         errors++;
         $display("FAIL raw_operand: valid=%b sr1=%h dest=%0d expected 1/BEEF/7",
                  out_valid, out_sr1, out_dest);
      end
      drive_wb(1, 7, 16'h0007); step();
      idle();
   endtask

   task automatic test_max_inflight();
      out_ready = 1;
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 0, 0, 0, 5, 1, WIDTH'(k));
         #1; checks++;
         if (in_ready !== (k < 3)) begin
            errors++; $display("FAIL waw_issue%0d: in_ready=%b expected %b", k, in_ready, k < 3);
         end
         if (k < 3) step();
      end
      step();
      drive_wb(1, 5, 16'h0005);
      #1; checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL waw_full_wb: in_ready=%b expected 0", in_ready);
      end
      step();
      drive_wb(0, 0, '0);
      #1; checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL waw_release: in_ready=%b expected 1", in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 16'h0003) begin
         errors++;
         $display("FAIL waw_fourth: valid=%b ctrl=%h expected 1/0003", out_valid, out_ctrl);
      end
      #1; checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL waw_still_full: in_ready=%b expected 0", in_ready);
      end
      idle();
      for (int k = 0; k < 3; k++) begin
         drive_wb(1, 5, 16'h0005); step();
      end
      idle();
   endtask

   task automatic test_backpressure();
      out_ready = 0;
      step();
      drive(1, 2, 1, 0, 0, 0, 0, 16'hAAAA);
      #1; checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_first: in_ready=%b expected 1", in_ready);
      end
      step();
      drive(1, 4, 1, 0, 0, 0, 0, 16'hBBBB);
      for (int c = 0; c < 5; c++) begin
         #1; checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sr1 !== 16'h0002 ||
             out_ctrl !== 16'hAAAA) begin
            errors++;
            $display("FAIL bp_hold%0d: ready=%b valid=%b sr1=%h ctrl=%h expected 0/1/0002/AAAA",
                     c, in_ready, out_valid, out_sr1, out_ctrl);
         end
         step();
      end
      out_ready = 1;
      #1; checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: in_ready=%b expected 1", in_ready);
      end
      step();
      idle();
      checks++;
      if (out_valid !== 1'b1 || out_sr1 !== 16'h0004 || out_ctrl !== 16'hBBBB) begin
         errors++;
         $display("FAIL bp_load: valid=%b sr1=%h ctrl=%h expected 1/0004/BBBB",
                  out_valid, out_sr1, out_ctrl);
      end
      step();
   endtask

   task automatic test_flush_wb();
      out_ready = 1;
      drive(1, 0, 0, 0, 0, 6, 1, 16'hF001); step();
      drive(1, 0, 0, 0, 0, 6, 1, 16'hF002); step();
      out_ready = 0;
      drive(1, 0, 0, 0, 0, 0, 0, 16'hCCCC);
      drive_wb(1, 6, 16'h0006);
      flush = 1;
      #1; checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL flush_block: in_ready=%b expected 0", in_ready);
      end
      step();
      flush = 0; drive_wb(0, 0, '0);
      drive(1, 6, 1, 0, 0, 0, 0, 16'hCC01);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_valid: out_valid=%b expected 0", out_valid);
      end
      #1; checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL flush_cnt_one: in_ready=%b expected 0", in_ready);
      end
      in_valid = 0;
      drive_wb(1, 6, 16'h0006); step();
      drive_wb(0, 0, '0);
      in_valid = 1;
      #1; checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_cnt_zero: in_ready=%b expected 1", in_ready);
      end
      step();
      idle();
      out_ready = 1;
      step();
   endtask

   task automatic test_async_reset();
      out_ready = 1;
      drive(1, 0, 0, 0, 0, 2, 1, 16'h2001); step();
      drive(1, 0, 0, 0, 0, 2, 1, 16'h2002); step();
      idle(); out_ready = 0;
      #2; reset = 1; m_reset();
      #1; checks++;
      if (out_valid !== 1'b0 || {out_sr1, out_sr2, out_ctrl, out_dest, out_dest_en} !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%b sr1=%h ctrl=%h dest=%0d expected all 0",
                  out_valid, out_sr1, out_ctrl, out_dest);
      end
      step();
      reset = 0; out_ready = 1;
      drive(1, 2, 1, 0, 0, 0, 0, 16'h2003);
      #1; checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL post_reset_ready: in_ready=%b expected 1", in_ready);
      end
      step();
      idle();
      checks++;
      if (out_valid !== 1'b1 || out_sr1 !== 16'h0000) begin
         errors++;
         $display("FAIL post_reset_read: valid=%b sr1=%h expected 1/0000", out_valid, out_sr1);
      end
      step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         drive($urandom_range(0, 9) < 7,
               $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 1) == 1,
               $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 1) == 1,
               $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 4) < 3,
               WIDTH'($urandom));
         drive_wb($urandom_range(0, 9) < 5, $urandom_range(0, NUM_REGS - 1), WIDTH'($urandom));
         flush     = $urandom_range(0, 24) == 0;
         out_ready = $urandom_range(0, 3) != 0;
         #1; checks++;
         if (in_ready !== m_ready()) begin
            errors++;
            $display("FAIL rnd_ready cycle %0d: in_ready=%b expected %b", c, in_ready, m_ready());
         end
         checks++;
         if ({out_valid, out_sr1, out_sr2, out_dest, out_dest_en, out_ctrl} !==
             {m_valid, m_sr1, m_sr2, m_dest, m_dest_en, m_ctrl}) begin
            errors++;
            $display("FAIL rnd_slot cycle %0d: got v=%b %h %h d=%0d e=%b c=%h expected v=%b %h %h d=%0d e=%b c=%h",
                     c, out_valid, out_sr1, out_sr2, out_dest, out_dest_en, out_ctrl,
                     m_valid, m_sr1, m_sr2, m_dest, m_dest_en, m_ctrl);
         end
         step();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_raw();
      test_max_inflight();
      test_backpressure();
      test_flush_wb();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule : tb_decode_issue_sb
`default_nettype wire
